// File: rtl/spi_slave_frame.sv
// SPI slave: deserialises {cmd, payload} frames from the master and serialises RAM read data on MISO.
// All bits move at one per clk; MOSI, SS_n and MISO are synchronous to clk.
module spi_slave_frame #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned TX_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MOSI,
   input  logic              SS_n,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              MISO,
   output logic              rx_valid,
   output logic [DATA_W+1:0] rx_data,
   output logic              busy,
   output logic              frame_err
);

   localparam int unsigned FrameW = DATA_W + 2;
   localparam int unsigned CntW   = $clog2(FrameW + 1);
   localparam int unsigned TmoW   = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

   localparam logic [CntW-1:0] LastBit = CntW'(FrameW - 1);
   localparam logic [CntW-1:0] LastTx  = CntW'(DATA_W - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TX_TIMEOUT - 1);

   localparam logic [1:0] CmdWrAddr = 2'b00;
   localparam logic [1:0] CmdWrData = 2'b01;
   localparam logic [1:0] CmdRdAddr = 2'b10;
   localparam logic [1:0] CmdRdData = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StWaitTx,
      StSend,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [FrameW-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic              miso_q, miso_d;
   logic              rx_valid_q, rx_valid_d;
   logic [FrameW-1:0] rx_data_q, rx_data_d;
   logic              busy_q, busy_d;
   logic              frame_err_q, frame_err_d;
   logic              pending_q, pending_d;
   logic [FrameW-1:0] frame;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      shift_d     = shift_q;
      tx_shift_d  = tx_shift_q;
      miso_d      = 1'b0;
      rx_valid_d  = 1'b0;
      rx_data_d   = rx_data_q;
      frame_err_d = 1'b0;
      pending_d   = pending_q;
      frame       = {shift_q[FrameW-2:0], MOSI};

      unique case (state_q)
         StIdle: begin
            if (!SS_n) begin
               state_d = StRecv;
            end
         end

         StRecv: begin
            if (SS_n) begin
               // Release before the first bit is a clean deselect, afterwards it is an abort.
               state_d     = StIdle;
               frame_err_d = (bit_cnt_q != '0);
            end else begin
               shift_d = frame;
               if (bit_cnt_q == LastBit) begin
                  state_d = StDone;
                  unique case (frame[FrameW-1 -: 2])
                     CmdWrAddr, CmdWrData: begin
                        rx_data_d  = frame;
                        rx_valid_d = 1'b1;
                     end
                     CmdRdAddr: begin
                        rx_data_d  = frame;
                        rx_valid_d = 1'b1;
                        pending_d  = 1'b1;
                     end
                     CmdRdData: begin
                        if (pending_q) begin
                           rx_data_d  = frame;
                           rx_valid_d = 1'b1;
                           pending_d  = 1'b0;
                           tmo_cnt_d  = '0;
                           state_d    = StWaitTx;
                        end else begin
                           frame_err_d = 1'b1;
                        end
                     end
                  endcase
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end
         end

         StWaitTx: begin
            if (SS_n) begin
               // Abort takes priority over a coincident tx_valid.
               state_d     = StIdle;
               frame_err_d = 1'b1;
            end else if (tx_valid) begin
               miso_d     = tx_data[DATA_W-1];
               tx_shift_d = tx_data << 1;
               bit_cnt_d  = '0;
               state_d    = StSend;
            end else if (TX_TIMEOUT != 0) begin
               if (tmo_cnt_q == TmoLast) begin
                  frame_err_d = 1'b1;
                  state_d     = StDone;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TmoW'(1);
               end
            end
         end

         StSend: begin
            if (SS_n) begin
               state_d     = StIdle;
               frame_err_d = 1'b1;
            end else if (bit_cnt_q == LastTx) begin
               state_d = StDone;
            end else begin
               miso_d     = tx_shift_q[DATA_W-1];
               tx_shift_d = tx_shift_q << 1;
               bit_cnt_d  = bit_cnt_q + CntW'(1);
            end
         end

         StDone: begin
            if (SS_n) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_d == StIdle) begin
         bit_cnt_d = '0;
         tmo_cnt_d = '0;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         shift_q     <= '0;
         tx_shift_q  <= '0;
         miso_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         shift_q     <= shift_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         pending_q   <= pending_d;
      end
   end

   assign MISO      = miso_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

   a_miso_only_in_send: assert property (@(posedge clk) disable iff (rst)
      (state_q != StSend) |-> !miso_q);
   a_busy_tracks_state: assert property (@(posedge clk) disable iff (rst)
      busy_q == (state_q != StIdle));
   a_valid_err_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(rx_valid_q && frame_err_q));

endmodule

// File: tb/tb_spi_slave_frame.sv
// Scoreboard bench for spi_slave_frame: an 8-bit instance (TX_TIMEOUT=4) and a 16-bit instance.
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares them.
module tb_spi_slave_frame;

   typedef struct {
      int          cyc;
      logic [17:0] data;
   } rx_t;

   typedef struct {
      int   cyc;
      logic b;
   } mb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mosi = 1'b0;
   logic        ss_a = 1'b1;
   logic        ss_b = 1'b1;
   logic        tx_valid = 1'b0;
   logic [15:0] tx_data = 16'h0000;

   logic        miso_a, rx_valid_a, busy_a, fe_a;
   logic [9:0]  rx_data_a;
   logic        miso_b, rx_valid_b, busy_b, fe_b;
   logic [17:0] rx_data_b;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   rx_t rq[$];
   int  eq[$];
   mb_t mq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_slave_frame #(.DATA_W(8), .TX_TIMEOUT(4)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .MOSI      (mosi),
      .SS_n      (ss_a),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data[7:0]),
      .MISO      (miso_a),
      .rx_valid  (rx_valid_a),
      .rx_data   (rx_data_a),
      .busy      (busy_a),
      .frame_err (fe_a)
   );

   spi_slave_frame #(.DATA_W(16)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .MOSI      (mosi),
      .SS_n      (ss_b),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .MISO      (miso_b),
      .rx_valid  (rx_valid_b),
      .rx_data   (rx_data_b),
      .busy      (busy_b),
      .frame_err (fe_b)
   );

   // The deselected instance must stay silent, so OR-ing both catches stray outputs.
   logic        miso_m, rx_valid_m, fe_m;
   logic [17:0] rx_data_m;
   assign miso_m     = miso_a | miso_b;
   assign rx_valid_m = rx_valid_a | rx_valid_b;
   assign fe_m       = fe_a | fe_b;
   assign rx_data_m  = rx_valid_b ? rx_data_b : {8'h00, rx_data_a};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      mb_t  m;
      rx_t  r;
      int   e;
      logic exp_b, exp_v, exp_e;
      exp_b = 1'b0;
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
         m     = mq.pop_front();
         exp_b = m.b;
      end
      check("miso", {31'd0, miso_m}, {31'd0, exp_b});
      exp_v = (rq.size() > 0 && rq[0].cyc == cyc);
      if (rx_valid_m || exp_v) begin
         check("rx_valid", {31'd0, rx_valid_m}, {31'd0, exp_v});
         if (exp_v) begin
            r = rq.pop_front();
            if (rx_valid_m) check("rx_data", {14'd0, rx_data_m}, {14'd0, r.data});
         end
      end
      exp_e = (eq.size() > 0 && eq[0] == cyc);
      if (fe_m || exp_e) begin
         check("frame_err", {31'd0, fe_m}, {31'd0, exp_e});
         if (exp_e) e = eq.pop_front();
      end
   end

   task automatic set_ss(input bit which, input logic v);
      if (which) ss_b = v;
      else ss_a = v;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Selects the slave, shifts nbits MSB first; returns at the negedge after the last bit edge.
   task automatic frame(input bit which, input logic [17:0] bits, input int nbits,
                        input bit exp_rx, input bit exp_err, output int e0);
      int  f;
      rx_t r;
      f = which ? 18 : 10;
      @(negedge clk);
      set_ss(which, 1'b0);
      e0 = cyc + 1;
      if (exp_rx) begin
         r.cyc  = e0 + f;
         r.data = bits;
         rq.push_back(r);
      end
      if (exp_err) eq.push_back(e0 + f);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         if (i == 0) check("busy_after_e0", {31'd0, which ? busy_b : busy_a}, 32'd1);
         mosi = bits[nbits-1-i];
      end
      @(negedge clk);
      mosi = 1'b0;
   endtask

   task automatic release_ss(input bit which, input bit exp_err);
      set_ss(which, 1'b1);
      if (exp_err) eq.push_back(cyc + 1);
      @(negedge clk);
      check("busy_idle", {31'd0, which ? busy_b : busy_a}, 32'd0);
   endtask

   task automatic send_tx(input logic [15:0] d, input int w);
      mb_t m;
      int  et;
      tx_valid = 1'b1;
      tx_data  = d;
      et = cyc + 1;
      for (int k = 0; k < w; k++) begin
         m.cyc = et + k;
         m.b   = d[w-1-k];
         mq.push_back(m);
      end
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      wait_neg(2);
      check("rst_miso", {31'd0, miso_a}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid_a}, 32'd0);
      check("rst_rx_data", {22'd0, rx_data_a}, 32'd0);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_frame_err", {31'd0, fe_a}, 32'd0);
      check("rst_busy_b", {31'd0, busy_b}, 32'd0);
      rst = 1'b0;

      // tx_valid while idle must be ignored
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 16'hFFFF;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_neg(2);

      // write address, then read-data with no pending read address
      frame(1'b0, 18'h0A5, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);
      frame(1'b0, 18'h300, 10, 1'b0, 1'b1, e0);
      release_ss(1'b0, 1'b0);

      // abort after 5 bits, then a clean write-data frame
      frame(1'b0, 18'h0D, 5, 1'b0, 1'b0, e0);
      release_ss(1'b0, 1'b1);
      frame(1'b0, 18'h13C, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);

      // repeated read address, read data, tx_valid three cycles after E10
      frame(1'b0, 18'h203, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);
      frame(1'b0, 18'h2AA, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);
      frame(1'b0, 18'h355, 10, 1'b1, 1'b0, e0);
      wait_neg(2);
      send_tx(16'h00C3, 8);
      wait_neg(10);
      release_ss(1'b0, 1'b0);

      // SS_n release coincident with tx_valid in WAIT_TX
      frame(1'b0, 18'h201, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);
      frame(1'b0, 18'h301, 10, 1'b1, 1'b0, e0);
      ss_a     = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 16'h00FF;
      eq.push_back(cyc + 1);
      @(negedge clk);
      tx_valid = 1'b0;
      check("busy_wait_abort", {31'd0, busy_a}, 32'd0);

      // tx_valid timeout at E10+4, late tx_valid in DONE ignored
      frame(1'b0, 18'h2FF, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);
      frame(1'b0, 18'h301, 10, 1'b1, 1'b0, e0);
      eq.push_back(e0 + 14);
      wait_neg(6);
      tx_valid = 1'b1;
      tx_data  = 16'h0081;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_neg(2);
      release_ss(1'b0, 1'b0);

      // 16-bit instance read sequence
      frame(1'b1, 18'h21234, 18, 1'b1, 1'b0, e0);
      release_ss(1'b1, 1'b0);
      frame(1'b1, 18'h30000, 18, 1'b1, 1'b0, e0);
      wait_neg(2);
      send_tx(16'hBEEF, 16);
      wait_neg(18);
      release_ss(1'b1, 1'b0);

      // reset asserted mid-SEND
      frame(1'b0, 18'h20F, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);
      frame(1'b0, 18'h3F0, 10, 1'b1, 1'b0, e0);
      send_tx(16'h00A5, 8);
      wait_neg(2);
      #2;
      rst = 1'b1;
      mq.delete();
      #1;
      check("rst_send_miso", {31'd0, miso_a}, 32'd0);
      check("rst_send_busy", {31'd0, busy_a}, 32'd0);
      check("rst_send_rx_data", {22'd0, rx_data_a}, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      ss_a = 1'b1;
      wait_neg(1);

      // reset clears a pending read address
      frame(1'b0, 18'h2C0, 10, 1'b1, 1'b0, e0);
      release_ss(1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      frame(1'b0, 18'h300, 10, 1'b0, 1'b1, e0);
      release_ss(1'b0, 1'b0);

      wait_neg(4);
      check("rx_queue_drained", rq.size(), 32'd0);
      check("err_queue_drained", eq.size(), 32'd0);
      check("miso_queue_drained", mq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
